matmul_host_seq: RTL and testbench
==================================

MATMUL_HOST_SEQ -- requirements
Module: matmul_host_seq

Interface
REQ-001 SHALL have one clock and reset; reset is asynchronous and active-high.
REQ-002 SHALL take parameter READ_DELAY, default 8, meaning idle cycles between the last load_en cycle and the first output_en cycle (legal range 7..255).
REQ-003 SHALL take parameter DONE_TIMEOUT, default 4, meaning the cycles to wait for done after the last read.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-high reset.
REQ-006 s_valid/s_ready/s_data  in/out/in  1/1/8  operand byte stream, order A0,A1,A2,A3,B0,B1,B2,B3.
REQ-007 load_en/load_sel_ab/load_index/in_data  out  1/1/2/8  operand write port toward the matmul controller.
REQ-008 output_en/output_sel  out  1/2  result read port toward the controller.
REQ-009 out_data/done  in  8/1  result byte, combinational on output_en/output_sel; controller completion flag.
REQ-010 r_valid/r_ready/r_data/r_last  out/in/out/out  1/1/8/1  result stream, order C00,C01,C10,C11.
REQ-011 busy/err  out  1/1  transaction in progress; sticky done-timeout flag.

Function
REQ-012 States SHALL be IDLE, LOAD, DELAY, READ, DONE_WAIT, DRAIN.
- IDLE->LOAD when s_valid=1.
- LOAD->DELAY after the 8th accepted byte.
- DELAY->READ after READ_DELAY cycles.
- READ->DONE_WAIT after 4 cycles.
- DONE_WAIT->DRAIN on done=1 or on timeout.
- DRAIN->IDLE on the r_last handshake.
REQ-013 s_ready SHALL be 1 only in LOAD and in IDLE; an accepted byte is s_valid&&s_ready.
REQ-014 Each accepted byte SHALL drive load_en=1 in the same cycle, with:
- in_data=s_data
- load_index=byte_count[1:0]
- load_sel_ab=byte_count[2]
REQ-015 load_en SHALL be 0 in any cycle with no accepted byte; s_valid gaps stall the byte count without error.
REQ-016 In READ, output_en SHALL be 1 for exactly 4 consecutive cycles, with output_sel=0,1,2,3, and out_data captured into buffer entry output_sel at each clock edge.
REQ-017 output_en SHALL be 0 in every other state; output_sel SHALL be 0 when output_en=0.
REQ-018 DONE_WAIT SHALL accept done in any cycle from the first DONE_WAIT cycle through cycle DONE_TIMEOUT.
REQ-019 In DRAIN, r_valid=1 and r_data=buf[rd_ptr]; rd_ptr increments on r_valid&&r_ready; r_last=1 when rd_ptr=3.
REQ-020 r_data/r_last SHALL hold stable while r_valid&&!r_ready.
REQ-021 busy SHALL be 0 only in IDLE.
REQ-022 Result bytes SHALL pass through unmodified; no arithmetic on data; counters wrap never (saturate at terminal value).
REQ-023 An IDLE cycle with s_valid=1 SHALL accept byte A0 (load_en=1) and enter LOAD, giving zero bubble between back-to-back transactions.
REQ-024 The block SHALL never assert load_en and output_en in the same cycle.

Reset
REQ-025 On rst:
- state=IDLE, counters=0, buffer=0
- all outputs 0, except s_ready, which SHALL be 1 one cycle after rst deasserts
REQ-026 Reset mid-transaction SHALL abandon it; partial loads are not resumed and no r_valid is emitted for it.

Configuration
REQ-027 Macro MATMUL_SEQ_TIMEOUT_EN defined: the DONE_WAIT timeout sets err=1 (sticky until rst) and proceeds to DRAIN.
REQ-028 Macro MATMUL_SEQ_TIMEOUT_EN undefined: DONE_WAIT waits indefinitely for done and err is tied 0.

Structure
REQ-029 Shared package tpu_pkg SHALL hold:
- the state enum type
- NUM_LOAD_BYTES=8
- NUM_RESULTS=4
REQ-030 One sub-module, matmul_result_buf, SHALL implement the 4x8 capture buffer with write index and read pointer.

Verification
REQ-031 Stream 1,2,3,4,5,6,7,8 with a behavioral controller computing [[1,2],[3,4]]x[[5,6],[7,8]] -> load_en pulses index 0..3 with sel 0 then 0..3 with sel 1; r_data 19,22,43,50; r_last on 50.
REQ-032 Same stimulus with s_valid low every other cycle and r_ready toggling 1,0,0,1 -> identical load sequence and outputs, no duplicated or dropped byte.
REQ-033 rst asserted after the 5th accepted byte, then a fresh stream 2,0,0,2,1,1,1,1 -> outputs 2,2,2,2; no output from the aborted transaction.
REQ-034 done held 0, with macro defined -> err=1 exactly DONE_TIMEOUT cycles into DONE_WAIT, then 4 results drained; without the macro -> block stays in DONE_WAIT and busy=1.
REQ-035 Two back-to-back streams with s_valid continuously 1 -> first byte of the second stream accepted in the cycle after the first r_last handshake.
REQ-036 Check, for scenario REQ-031, that exactly READ_DELAY=8 cycles separate the last load_en from the first output_en.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the matmul host sequencer slice.
// Holds the sequencer state type and the transaction shape constants:
// NUM_LOAD_BYTES operand bytes in (A0..A3, B0..B3) and NUM_RESULTS bytes out
// (C00, C01, C10, C11).
package tpu_pkg;

    localparam int NUM_LOAD_BYTES = 8;
    localparam int NUM_RESULTS    = 4;
    localparam int PTR_W          = $clog2(NUM_RESULTS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DELAY     = 3'd2,
        ST_READ      = 3'd3,
        ST_DONE_WAIT = 3'd4,
        ST_DRAIN     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/matmul_host_seq_if.sv
// Bus bundle between the host sequencer and its environment.
//   s_*      : operand byte stream into the sequencer (valid/ready)
//   load_*   : operand write port toward the matmul controller
//   output_* : result read port toward the controller, out_data/done back
//   r_*      : result byte stream out of the sequencer (valid/ready)
//   busy/err : status
// modport master = sequencer side, modport slave = environment side.
interface matmul_host_seq_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] in_data;

    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] out_data;
    logic       done;

    logic       r_valid;
    logic       r_ready;
    logic [7:0] r_data;
    logic       r_last;

    logic       busy;
    logic       err;

    modport master (
        input  s_valid, s_data, out_data, done, r_ready,
        output s_ready, load_en, load_sel_ab, load_index, in_data,
        output output_en, output_sel, r_valid, r_data, r_last, busy, err
    );

    modport slave (
        output s_valid, s_data, out_data, done, r_ready,
        input  s_ready, load_en, load_sel_ab, load_index, in_data,
        input  output_en, output_sel, r_valid, r_data, r_last, busy, err
    );

endinterface

// File: rtl/matmul_result_buf.sv
// Result capture buffer: NUM_RESULTS entries of DATA_W bits.
// Ports:
//   clk, rst          clock, async active-high reset (clears entries and pointer)
//   wr_en/wr_idx/wr_data  capture one result byte at index wr_idx
//   rd_adv            advance read pointer (saturates at last entry)
//   rd_clr            return read pointer to 0 (wins over rd_adv)
//   rd_ptr/rd_data    current read pointer and the entry it selects
// Entries need a reset value, so they are plain registers with a
// combinational read mux rather than a RAM.
module matmul_result_buf
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_adv,
    input  logic              rd_clr,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] entry_rd [NUM_RESULTS];
    logic [PTR_W-1:0]  rd_ptr_reg;

    generate
        for (genvar gi = 0; gi < NUM_RESULTS; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
        end else if (rd_clr) begin
            rd_ptr_reg <= '0;
        end else if (rd_adv && (rd_ptr_reg != PTR_W'(NUM_RESULTS - 1))) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign rd_ptr  = rd_ptr_reg;
    assign rd_data = entry_rd[rd_ptr_reg];

endmodule

// File: rtl/matmul_host_seq.sv
// Host-side sequencer for a 2x2 byte matmul controller.
// Accepts 8 operand bytes (A0..A3, B0..B3) on the s_* stream and forwards
// each one to the controller write port in the same cycle, waits READ_DELAY
// idle cycles, reads the 4 result bytes over output_en/output_sel, waits for
// done, then streams C00, C01, C10, C11 out on r_* with r_last on C11.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  matmul_host_seq_if.master (streams, controller ports, busy/err)
// Parameters:
//   READ_DELAY    idle cycles between last load_en and first output_en (7..255)
//   DONE_TIMEOUT  cycles to wait for done after the last read
// Build option:
//   MATMUL_SEQ_TIMEOUT_EN  when defined, a missing done times out after
//   DONE_TIMEOUT cycles, sets sticky err and drains anyway; otherwise the
//   sequencer waits for done indefinitely and err is held at 0.
module matmul_host_seq
    import tpu_pkg::*;
#(
    parameter int READ_DELAY   = 8,
    parameter int DONE_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst,
    matmul_host_seq_if.master bus
);

    localparam logic [2:0] BYTE_LAST    = 3'(NUM_LOAD_BYTES - 1);
    localparam logic [7:0] DELAY_LAST   = 8'(READ_DELAY - 1);
    localparam logic [7:0] READ_LAST    = 8'(NUM_RESULTS - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);

    seq_state_t       state_reg;
    logic [2:0]       byte_cnt_reg;
    // Shared phase counter: DELAY length, READ select, DONE_WAIT age.
    logic [7:0]       phase_cnt_reg;
    // Holds s_ready low in reset and for the first cycle after it.
    logic             ready_ok_reg;

    logic             accept;
    logic             rd_handshake;
    logic             last_handshake;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       rd_data;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic             err_reg;
`endif

    assign bus.s_ready = ready_ok_reg &&
                         ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));
    assign accept      = bus.s_valid && bus.s_ready;

    // Operand write port: live only for accepted bytes.
    assign bus.load_en     = accept;
    assign bus.in_data     = accept ? bus.s_data : 8'd0;
    assign bus.load_index  = accept ? byte_cnt_reg[1:0] : 2'd0;
    assign bus.load_sel_ab = accept && byte_cnt_reg[2];

    assign bus.output_en  = (state_reg == ST_READ);
    assign bus.output_sel = bus.output_en ? phase_cnt_reg[1:0] : 2'd0;

    assign bus.r_valid   = (state_reg == ST_DRAIN);
    assign bus.r_data    = bus.r_valid ? rd_data : 8'd0;
    assign bus.r_last    = bus.r_valid && (rd_ptr == PTR_W'(NUM_RESULTS - 1));
    assign rd_handshake   = bus.r_valid && bus.r_ready;
    assign last_handshake = rd_handshake && bus.r_last;

    assign bus.busy = (state_reg != ST_IDLE);

`ifdef MATMUL_SEQ_TIMEOUT_EN
    assign bus.err = err_reg;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            byte_cnt_reg  <= '0;
            phase_cnt_reg <= '0;
            ready_ok_reg  <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            ready_ok_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    // The first byte is taken directly from IDLE so that
                    // back-to-back transactions have no bubble.
                    if (accept) begin
                        state_reg    <= ST_LOAD;
                        byte_cnt_reg <= 3'd1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (byte_cnt_reg == BYTE_LAST) begin
                            state_reg     <= ST_DELAY;
                            byte_cnt_reg  <= '0;
                            phase_cnt_reg <= '0;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 3'd1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (phase_cnt_reg == DELAY_LAST) begin
                        state_reg     <= ST_READ;
                        phase_cnt_reg <= '0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end
                ST_READ: begin
                    if (phase_cnt_reg == READ_LAST) begin
                        state_reg     <= ST_DONE_WAIT;
                        phase_cnt_reg <= '0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end
                ST_DONE_WAIT: begin
                    // done wins over the timeout in the final waiting cycle.
                    if (bus.done) begin
                        state_reg     <= ST_DRAIN;
                        phase_cnt_reg <= '0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                    end else if (phase_cnt_reg == TIMEOUT_LAST) begin
                        state_reg     <= ST_DRAIN;
                        phase_cnt_reg <= '0;
                        err_reg       <= 1'b1;
`endif
                    end else if (phase_cnt_reg != TIMEOUT_LAST) begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (last_handshake) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    matmul_result_buf #(
        .DATA_W (8)
    ) u_result_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.output_en),
        .wr_idx  (bus.output_sel),
        .wr_data (bus.out_data),
        .rd_adv  (rd_handshake),
        .rd_clr  (last_handshake),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_matmul_host_seq.sv
// Self-checking bench for matmul_host_seq.
// A behavioral matmul controller answers the load/read ports; the stimulus
// driver pushes expected load-port writes and expected result bytes into
// queues, and a negedge monitor pops and compares them as the DUT produces
// them. Honors MATMUL_SEQ_TIMEOUT_EN for the done-timeout scenario.
module tb_matmul_host_seq;

    localparam int RD = 8;
    localparam int DT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matmul_host_seq_if bus ();

    matmul_host_seq #(
        .READ_DELAY   (RD),
        .DONE_TIMEOUT (DT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int load_q[$];
    int res_q[$];

    logic [7:0] a_mem [4];
    logic [7:0] b_mem [4];
    logic [7:0] ctrl_c [4];
    logic       done_en;
    logic       rr_toggle;
    int         rr_k;

    int         last_load_cyc, first_oe_cyc, last_oe_cyc, oe_cnt;
    int         err_cyc, rlast_cyc, gap_val, overlap_cnt, unexp_cnt, bad_sel_cnt;
    bit         after_rlast, stall_prev;
    int         stall_val;

    // Behavioral controller: combinational result read, done from the bench.
    assign bus.out_data = bus.output_en ? ctrl_c[bus.output_sel] : 8'd0;
    assign bus.done     = done_en;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected C[k] (k = 2*row + col) from the raw stream bytes A0..A3,B0..B3.
    function automatic logic [7:0] mm(input logic [7:0] m [8], input int k);
        int row;
        int col;
        logic [15:0] s;
        row = k / 2;
        col = k % 2;
        s = 16'(m[2*row]) * 16'(m[4+col]) + 16'(m[2*row+1]) * 16'(m[6+col]);
        return s[7:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.r_ready = rr_toggle ? ((rr_k % 4 == 0) || (rr_k % 4 == 3)) : 1'b1;
            rr_k++;
        end
    end

    // Monitor: controller writes, protocol observations, scoreboard pops.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.load_en && bus.output_en) overlap_cnt++;
                if (!bus.output_en && (bus.output_sel != 2'd0)) bad_sel_cnt++;

                if (bus.load_en) begin
                    if (load_q.size() == 0) begin
                        unexp_cnt++;
                    end else begin
                        chk("load_port",
                            int'({bus.load_sel_ab, bus.load_index, bus.in_data}),
                            load_q.pop_front());
                    end
                    if (bus.load_sel_ab) b_mem[bus.load_index] = bus.in_data;
                    else                 a_mem[bus.load_index] = bus.in_data;
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < 2; c++) begin
                            ctrl_c[2*r+c] = 8'(a_mem[2*r] * b_mem[c] + a_mem[2*r+1] * b_mem[2+c]);
                        end
                    end
                    last_load_cyc = cyc;
                    if (after_rlast) begin
                        gap_val     = cyc - rlast_cyc;
                        after_rlast = 1'b0;
                    end
                end

                if (bus.output_en) begin
                    chk("output_sel", int'(bus.output_sel), oe_cnt % 4);
                    if (first_oe_cyc < 0) first_oe_cyc = cyc;
                    last_oe_cyc = cyc;
                    oe_cnt++;
                end

                if (bus.err && (err_cyc < 0)) err_cyc = cyc;

                if (stall_prev && bus.r_valid) begin
                    chk("r_hold", int'({bus.r_last, bus.r_data}), stall_val);
                end
                stall_prev = bus.r_valid && !bus.r_ready;
                stall_val  = int'({bus.r_last, bus.r_data});

                if (bus.r_valid && bus.r_ready) begin
                    $display("result data=%0d last=%0d cyc=%0d", bus.r_data, bus.r_last, cyc);
                    if (res_q.size() == 0) begin
                        unexp_cnt++;
                    end else begin
                        chk("r_data_last", int'({bus.r_last, bus.r_data}), res_q.pop_front());
                    end
                    if (bus.r_last) begin
                        rlast_cyc   = cyc;
                        after_rlast = 1'b1;
                    end
                end
            end
        end
    end

    task automatic clear_track();
        first_oe_cyc = -1;
        oe_cnt       = 0;
        err_cyc      = -1;
        gap_val      = -1;
        after_rlast  = 1'b0;
        unexp_cnt    = 0;
        overlap_cnt  = 0;
        bad_sel_cnt  = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        stall_prev  = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_load_en", int'(bus.load_en), 0);
        chk("rst_output_en", int'(bus.output_en), 0);
        chk("rst_r_valid", int'(bus.r_valid), 0);
        chk("rst_err", int'(bus.err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_first_cycle", int'(bus.s_ready), 0);
        @(negedge clk);
        chk("s_ready_after_one", int'(bus.s_ready), 1);
    endtask

    // Drives bytes[0..stop_after-1]; expectations are pushed as each byte is
    // first presented, results when the last byte of a group of 8 is presented.
    task automatic drive_stream(input logic [7:0] bytes [16], input int stop_after,
                                input bit gaps, input bit push_res);
        int i = 0;
        int k = 0;
        int n = 0;
        int pushed = -1;
        logic v;
        logic [7:0] m [8];
        while ((i < stop_after) && (n < 2000)) begin
            @(posedge clk);
            #1;
            v = gaps ? (k % 2 == 0) : 1'b1;
            k++;
            bus.s_valid = v;
            bus.s_data  = bytes[i];
            if (v && (i > pushed)) begin
                pushed = i;
                load_q.push_back((((i % 8) / 4) << 10) | ((i % 4) << 8) | int'(bytes[i]));
                if ((i % 8 == 7) && push_res) begin
                    for (int j = 0; j < 8; j++) m[j] = bytes[i - 7 + j];
                    for (int r = 0; r < 4; r++) res_q.push_back(((r == 3) << 8) | int'(mm(m, r)));
                end
            end
            @(negedge clk);
            if (v && bus.s_ready) i++;
            n++;
        end
        if (i < stop_after) chk("drive_timeout", i, stop_after);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((res_q.size() != 0) && (n < 3000)) begin
            @(posedge clk);
            n++;
        end
        if (res_q.size() != 0) chk("drain_timeout", res_q.size(), 0);
        @(negedge clk);
    endtask

    logic [7:0] stim [16];

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.r_ready = 1'b1;
        done_en     = 1'b1;
        rr_toggle   = 1'b0;
        rr_k        = 0;
        stall_prev  = 1'b0;
        last_load_cyc = 0;
        last_oe_cyc   = 0;
        rlast_cyc     = 0;
        stall_val     = 0;
        for (int j = 0; j < 4; j++) begin
            a_mem[j]  = 8'd0;
            b_mem[j]  = 8'd0;
            ctrl_c[j] = 8'd0;
        end
        clear_track();
        do_reset();

        // Basic product, latency from last load to first read.
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_track();
        drive_stream(stim, 8, 1'b0, 1'b1);
        wait_drain();
        chk("load_to_read_gap", first_oe_cyc - last_load_cyc, RD + 1);
        chk("read_count", oe_cnt, 4);
        chk("idle_after_drain", int'(bus.busy), 0);
        chk("no_overlap", overlap_cnt, 0);
        chk("sel_zero_when_idle", bad_sel_cnt, 0);

        // Gapped input and throttled output.
        clear_track();
        rr_toggle = 1'b1;
        rr_k      = 0;
        drive_stream(stim, 8, 1'b1, 1'b1);
        wait_drain();
        rr_toggle = 1'b0;
        chk("gap_read_count", oe_cnt, 4);
        chk("gap_unexpected", unexp_cnt, 0);

        // Abort after 5 bytes, then a fresh transaction.
        clear_track();
        drive_stream(stim, 5, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        chk("abort_loads_seen", load_q.size(), 0);
        do_reset();
        stim = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1,
                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        drive_stream(stim, 8, 1'b0, 1'b1);
        wait_drain();
        chk("abort_unexpected", unexp_cnt, 0);
        chk("abort_read_count", oe_cnt, 4);

        // Back-to-back streams with s_valid held high.
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                 8'd9, 8'd3, 8'd250, 8'd7, 8'd11, 8'd2, 8'd4, 8'd200};
        clear_track();
        drive_stream(stim, 16, 1'b0, 1'b1);
        wait_drain();
        chk("b2b_zero_bubble", gap_val, 1);
        chk("b2b_read_count", oe_cnt, 8);
        chk("b2b_no_overlap", overlap_cnt, 0);

        // done never arrives.
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_track();
        done_en = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        drive_stream(stim, 8, 1'b0, 1'b1);
        wait_drain();
        chk("err_latency", err_cyc - last_oe_cyc, DT + 1);
        chk("err_sticky", int'(bus.err), 1);
        chk("timeout_unexpected", unexp_cnt, 0);
        done_en = 1'b1;
        do_reset();
        chk("err_cleared", int'(bus.err), 0);
`else
        drive_stream(stim, 8, 1'b0, 1'b0);
        repeat (RD + 40) @(negedge clk);
        chk("wait_busy", int'(bus.busy), 1);
        chk("wait_r_valid", int'(bus.r_valid), 0);
        chk("wait_err", int'(bus.err), 0);
        chk("wait_read_count", oe_cnt, 4);
        do_reset();
        done_en = 1'b1;
        chk("wait_unexpected", unexp_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
